board_lock_clear: RTL and testbench

//  Write-side partner of the bottom-contact check for the 12x12 Tetris board.

---
 rtl/board_lock_clear_pkg.sv | 19 +
 rtl/board_row_shift.sv | 40 ++++
 rtl/board_lock_clear.sv | 126 ++++++++++++
 tb/tb_board_lock_clear.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_lock_clear_pkg.sv
// board_lock_clear_pkg
//   Shared constants for the 12x12 board lock/clear datapath.
//   Cell index = COLS*row + col; row 0 is the top row.
//   Exports board geometry, the row-pointer width and the FSM state codes.
package board_lock_clear_pkg;

  localparam int COLS  = 12;
  localparam int ROWS  = 12;
  localparam int CELLS = ROWS * COLS;
  localparam int ROW_W = 4;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  // FSM encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/board_row_shift.sv
// board_row_shift
//   Combinational helper for the clear sweep: reports whether the selected
//   row is full and produces the board with that row removed (rows above it
//   move down by one, the top row becomes empty).
//   Ports:
//     board_i     in  CELLS  current board
//     row_i       in  ROW_W  row under test
//     row_full_o  out 1      all cells of row_i are set
//     shifted_o   out CELLS  board with row_i removed
module board_row_shift
  import board_lock_clear_pkg::*;
(
  input  logic [CELLS-1:0] board_i,
  input  logic [ROW_W-1:0] row_i,
  output logic             row_full_o,
  output logic [CELLS-1:0] shifted_o
);

  // One flag per possible pointer value; codes beyond the board read as not full.
  logic [(2**ROW_W)-1:0] row_all;

  assign row_all[(2**ROW_W)-1:ROWS] = '0;

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    assign row_all[gi] = &board_i[gi*COLS +: COLS];

    if (gi == 0) begin : g_top
      // The top row is always at or above the removed row, so it empties.
      assign shifted_o[0 +: COLS] = '0;
    end else begin : g_body
      // Rows below the removed one stay put; the rest take the row above.
      assign shifted_o[gi*COLS +: COLS] = (ROW_W'(gi) > row_i) ?
                                          board_i[gi*COLS +: COLS] :
                                          board_i[(gi-1)*COLS +: COLS];
    end
  end

  assign row_full_o = row_all[row_i];

endmodule

// File: rtl/board_lock_clear.sv
// board_lock_clear
//   Merges a landed piece into the background board, then sweeps rows from
//   the bottom up, removing full rows one per cycle.
//   Ports:
//     clk            in   1      rising-edge clock
//     reset          in   1      asynchronous active-high reset
//     lock_req       in   1      piece landed; accepted only when idle
//     currentSqs     in   CELLS  piece occupancy, sampled on accept
//     board_clr      in   1      synchronous new-game clear, highest priority
//     backGround     out  CELLS  registered board
//     busy           out  1      merge/sweep in progress
//     done           out  1      one-cycle completion pulse
//     lines_cleared  out  4      rows removed by the last lock
//     lines_total    out  CNT_W  saturating count of removed rows
//     game_over      out  1      sticky: top row occupied after a lock
module board_lock_clear
  import board_lock_clear_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lock_req,
  input  logic [CELLS-1:0] currentSqs,
  input  logic             board_clr,
  output logic [CELLS-1:0] backGround,
  output logic             busy,
  output logic             done,
  output logic [3:0]       lines_cleared,
  output logic [CNT_W-1:0] lines_total,
  output logic             game_over
);

  logic [1:0]       state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [CELLS-1:0] board_q, board_d;
  logic [3:0]       lines_cleared_q, lines_cleared_d;
  logic [CNT_W-1:0] lines_total_q, lines_total_d;
  logic             game_over_q, game_over_d;

  logic             row_full;
  logic [CELLS-1:0] board_shifted;

  board_row_shift u_row_shift (
    .board_i    (board_q),
    .row_i      (row_q),
    .row_full_o (row_full),
    .shifted_o  (board_shifted)
  );

  always_comb begin
    state_d         = state_q;
    row_d           = row_q;
    board_d         = board_q;
    lines_cleared_d = lines_cleared_q;
    lines_total_d   = lines_total_q;
    game_over_d     = game_over_q;

    if (board_clr) begin
      state_d         = ST_IDLE;
      row_d           = LAST_ROW;
      board_d         = '0;
      lines_cleared_d = '0;
      lines_total_d   = '0;
      game_over_d     = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (lock_req) begin
            board_d         = board_q | currentSqs;
            lines_cleared_d = '0;
            row_d           = LAST_ROW;
            state_d         = ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (row_full) begin
            // Stay on the same row: the row that dropped into it may be full too.
            board_d         = board_shifted;
            lines_cleared_d = lines_cleared_q + 4'd1;
            if (lines_total_q != '1) begin
              lines_total_d = lines_total_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end else if (row_q != '0) begin
            row_d = row_q - {{(ROW_W-1){1'b0}}, 1'b1};
          end else begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (board_q[COLS-1:0] != '0) begin
            game_over_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      row_q           <= LAST_ROW;
      board_q         <= '0;
      lines_cleared_q <= '0;
      lines_total_q   <= '0;
      game_over_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      row_q           <= row_d;
      board_q         <= board_d;
      lines_cleared_q <= lines_cleared_d;
      lines_total_q   <= lines_total_d;
      game_over_q     <= game_over_d;
    end
  end

  assign backGround    = board_q;
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign lines_cleared = lines_cleared_q;
  assign lines_total   = lines_total_q;
  assign game_over     = game_over_q;

endmodule

// File: tb/tb_board_lock_clear.sv
// tb_board_lock_clear
//   Directed and random locks against a row-list model of the board.
module tb_board_lock_clear;

  localparam int COLS  = 12;
  localparam int ROWS  = 12;
  localparam int CELLS = 144;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             lock_req = 1'b0;
  logic             board_clr = 1'b0;
  logic [CELLS-1:0] currentSqs = '0;
  logic [CELLS-1:0] backGround;
  logic             busy;
  logic             done;
  logic [3:0]       lines_cleared;
  logic [CNT_W-1:0] lines_total;
  logic             game_over;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [CELLS-1:0] m_bg = '0;
  int               m_total = 0;
  bit               m_go = 1'b0;
  int               m_last_k = 0;

  board_lock_clear #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .lock_req      (lock_req),
    .currentSqs    (currentSqs),
    .board_clr     (board_clr),
    .backGround    (backGround),
    .busy          (busy),
    .done          (done),
    .lines_cleared (lines_cleared),
    .lines_total   (lines_total),
    .game_over     (game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [CELLS-1:0] obs, input logic [CELLS-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [CELLS-1:0] span(input int lo, input int hi);
    logic [CELLS-1:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Merge, then keep only non-full rows, packed against the bottom in order.
  function automatic int model_lock(input logic [CELLS-1:0] piece);
    logic [COLS-1:0]  keep[$];
    logic [CELLS-1:0] b;
    int               k = 0;
    b = m_bg | piece;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (b[r*COLS +: COLS] == {COLS{1'b1}}) k++;
      else keep.push_back(b[r*COLS +: COLS]);
    end
    b = '0;
    for (int i = 0; i < keep.size(); i++) b[(ROWS-1-i)*COLS +: COLS] = keep[i];
    m_bg     = b;
    m_total  = (m_total + k > 65535) ? 65535 : m_total + k;
    if (b[COLS-1:0] != '0) m_go = 1'b1;
    m_last_k = k;
    return k;
  endfunction

  task automatic model_clr();
    m_bg = '0; m_total = 0; m_go = 1'b0; m_last_k = 0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_bg"}, backGround, m_bg);
    chk({tag, "_lines"}, lines_cleared, m_last_k);
    chk({tag, "_total"}, lines_total, m_total);
    chk({tag, "_gameover"}, game_over, m_go);
  endtask

  // Present a piece for one edge; returns in cycle 1 after the accept edge.
  task automatic start_lock(input logic [CELLS-1:0] piece);
    lock_req   = 1'b1;
    currentSqs = piece;
    @(posedge clk); #1;
    lock_req   = 1'b0;
    currentSqs = '0;
  endtask

  // Called in cycle c0; follows busy to its end and checks timing.
  task automatic wait_finish(input int c0, input int k, input string tag);
    int done_cyc = 0;
    int busy_cnt = 0;
    int dn_cnt   = 0;
    int c        = c0;
    bit fin      = 1'b0;
    while (!fin && c <= 40) begin
      if (busy) busy_cnt++;
      if (done) begin
        dn_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (!busy) fin = 1'b1;
      else begin
        @(posedge clk); #1;
        c++;
      end
    end
    chk({tag, "_finished"}, fin, 1'b1);
    chk({tag, "_done_cycle"}, done_cyc, 13 + k);
    chk({tag, "_busy_cycles"}, busy_cnt, 13 + k - c0 + 1);
    chk({tag, "_done_pulses"}, dn_cnt, 1);
  endtask

  task automatic do_lock(input logic [CELLS-1:0] piece, input string tag);
    int k;
    k = model_lock(piece);
    start_lock(piece);
    wait_finish(1, k, tag);
    check_model(tag);
    $display("lock %s: rows_cleared=%0d total=%0d game_over=%0d", tag, lines_cleared, lines_total, game_over);
  endtask

  task automatic do_clr(input string tag);
    board_clr = 1'b1;
    @(posedge clk); #1;
    board_clr = 1'b0;
    model_clr();
    chk({tag, "_clr_bg"}, backGround, '0);
    chk({tag, "_clr_total"}, lines_total, '0);
    chk({tag, "_clr_gameover"}, game_over, 1'b0);
    chk({tag, "_clr_busy"}, busy, 1'b0);
    $display("clear %s", tag);
  endtask

  initial begin
    logic [CELLS-1:0] p;
    int               k;
    int               r;
    int               dn;

    // 1: reset and idle
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_bg", backGround, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_lines", lines_cleared, '0);
    chk("rst_total", lines_total, '0);
    chk("rst_gameover", game_over, 1'b0);
    dn = 0;
    for (int i = 0; i < 5; i++) begin
      if (done || busy) dn++;
      @(posedge clk); #1;
    end
    chk("idle_no_done_busy", dn, 0);
    $display("reset and idle");

    // 2: partial bottom row
    do_lock(span(132, 137), "t2");
    chk("t2_bg_exact", backGround, span(132, 137));
    chk("t2_lines0", lines_cleared, 4'd0);

    // 3: complete row 11 with a cell above it
    do_clr("t3");
    do_lock(span(132, 142), "t3a");
    p = '0; p[143] = 1'b1; p[120] = 1'b1;
    do_lock(p, "t3b");
    p = '0; p[132] = 1'b1;
    chk("t3_bg_exact", backGround, p);
    chk("t3_lines1", lines_cleared, 4'd1);

    // 4: rows 11 and 9 full around a sparse row 10
    do_clr("t4");
    p = span(132, 142) | span(108, 118);
    p[124] = 1'b1;
    do_lock(p, "t4a");
    p = '0; p[143] = 1'b1; p[119] = 1'b1;
    do_lock(p, "t4b");
    p = '0; p[136] = 1'b1;
    chk("t4_bg_exact", backGround, p);
    chk("t4_lines2", lines_cleared, 4'd2);
    chk("t4_total2", lines_total, 16'd2);

    // 5a: lock_req pulsed while busy is dropped
    do_clr("t5");
    k = model_lock(span(132, 136));
    start_lock(span(132, 136));
    @(posedge clk); #1;
    lock_req = 1'b1; currentSqs = span(0, 11) | span(137, 143);
    @(posedge clk); #1;
    lock_req = 1'b0; currentSqs = '0;
    wait_finish(3, k, "t5a");
    check_model("t5a");
    $display("lock t5a with ignored request: rows_cleared=%0d", lines_cleared);

    // 5b: board_clr in cycle 5 of the sweep
    start_lock(span(96, 107));
    repeat (4) begin @(posedge clk); #1; end
    board_clr = 1'b1;
    @(posedge clk); #1;
    board_clr = 1'b0;
    model_clr();
    chk("t5b_bg", backGround, '0);
    chk("t5b_busy", busy, 1'b0);
    chk("t5b_lines", lines_cleared, '0);
    dn = 0;
    for (int i = 0; i < 16; i++) begin
      if (done) dn++;
      @(posedge clk); #1;
    end
    chk("t5b_no_done", dn, 0);
    $display("clear during sweep");

    // 5c: board_clr and lock_req together in idle
    do_lock(span(132, 133), "t5c_pre");
    board_clr = 1'b1; lock_req = 1'b1; currentSqs = span(120, 125);
    @(posedge clk); #1;
    board_clr = 1'b0; lock_req = 1'b0; currentSqs = '0;
    model_clr();
    chk("t5c_busy", busy, 1'b0);
    chk("t5c_bg", backGround, '0);
    $display("clear wins over simultaneous lock");

    // Full board: every row removed
    do_lock({CELLS{1'b1}}, "full");
    chk("full_lines12", lines_cleared, 4'd12);
    chk("full_bg", backGround, '0);

    // 6: game over is sticky
    do_clr("t6");
    p = '0; p[3] = 1'b1;
    do_lock(p, "t6a");
    chk("t6a_gameover", game_over, 1'b1);
    do_lock(span(132, 134), "t6b");
    chk("t6b_gameover_sticky", game_over, 1'b1);

    // Async reset in the middle of a sweep
    start_lock(span(140, 141));
    repeat (3) begin @(posedge clk); #1; end
    #2 reset = 1'b1;
    #1;
    model_clr();
    chk("areset_bg", backGround, '0);
    chk("areset_busy", busy, 1'b0);
    chk("areset_done", done, 1'b0);
    chk("areset_total", lines_total, '0);
    chk("areset_gameover", game_over, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    $display("async reset during sweep");

    p = '0; p[5] = 1'b1;
    do_lock(p, "t6c");
    chk("t6c_gameover", game_over, 1'b1);
    do_clr("t6d");
    chk("t6d_gameover_drop", game_over, 1'b0);

    // Random locks, biased toward completing rows
    for (int n = 0; n < 40; n++) begin
      if (n % 10 == 0) do_clr("rnd");
      p = '0;
      repeat ($urandom_range(4, 1)) p[$urandom_range(CELLS - 1, 0)] = 1'b1;
      if ($urandom_range(1, 0) == 1) begin
        r = $urandom_range(11, 6);
        p[r*COLS +: COLS] = ~m_bg[r*COLS +: COLS];
      end
      if ($urandom_range(3, 0) == 0) begin
        r = $urandom_range(11, 3);
        p[r*COLS +: COLS] = ~m_bg[r*COLS +: COLS];
      end
      do_lock(p, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
